// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: CPU-side SPI transaction sequencer with TX/RX FIFOs and chip-select framing
module spi_xfer_ctrl #(
    parameter int W_Data = 32,
    parameter int Depth  = 4,
    parameter int W_Ptr  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [W_Data-1:0] wr_data,
    output logic              tx_full,
    input  logic              rd_en,
    output logic [W_Data-1:0] rd_data,
    output logic              rx_empty,
    output logic              rx_overflow,
    input  logic              clr_ovf,
    output logic              busy,
    output logic              cs_n,
    output logic              transmit_start,
    output logic [W_Data-1:0] data_to_transmit,
    input  logic              transmit_ready,
    output logic              receive_start,
    input  logic              receive_ready,
    input  logic [W_Data-1:0] data_in
);
    typedef enum logic [2:0] {IDLE, SETUP, LAUNCH, ARM, SHIFT, CAPTURE, GAP} state_t;
    localparam logic [W_Ptr:0] FULL = (W_Ptr+1)'(Depth);
    state_t state, state_nx;
    logic [W_Data-1:0] tx_mem [Depth];
    logic [W_Data-1:0] rx_mem [Depth];
    logic [W_Ptr-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [W_Ptr:0] tx_cnt, rx_cnt;
    logic tx_empty, rx_full, tx_push, tx_pop, rx_push, rx_pop, ovf_set;
    assign tx_full  = tx_cnt == FULL;
    assign tx_empty = tx_cnt == '0;
    assign rx_full  = rx_cnt == FULL;
    assign rx_empty = rx_cnt == '0;
    assign rd_data  = rx_mem[rx_rp];
    assign busy     = state != IDLE || !tx_empty;
    // A full TX FIFO still accepts a word when the head leaves in the same cycle
    assign tx_push  = wr_en && (!tx_full || tx_pop);
    assign rx_pop   = rd_en && !rx_empty;
    // A CPU read in the CAPTURE cycle frees the slot the received word needs
    assign rx_push  = state == CAPTURE && (!rx_full || rx_pop);
    assign ovf_set  = state == CAPTURE && rx_full && !rx_pop;
    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // Next-state decode; the TX pop happens on the IDLE->SETUP transition
    always_comb begin
        state_nx = state;
        tx_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty && transmit_ready && receive_ready) begin
                    tx_pop   = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP:   state_nx = LAUNCH;
            LAUNCH:  state_nx = ARM;
            ARM:     state_nx = transmit_ready ? ARM : SHIFT;
            SHIFT:   state_nx = (transmit_ready && receive_ready) ? CAPTURE : SHIFT;
            CAPTURE: state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= wr_data;
        if (rx_push) rx_mem[rx_wp] <= data_in;
    end
    // FIFO pointers and occupancy counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop) tx_rp <= tx_rp + 1'b1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            tx_cnt <= tx_cnt + (W_Ptr+1)'(tx_push) - (W_Ptr+1)'(tx_pop);
            rx_cnt <= rx_cnt + (W_Ptr+1)'(rx_push) - (W_Ptr+1)'(rx_pop);
        end
    end
    // Registered SPI-side outputs decoded from the upcoming state; overflow set beats clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n             <= 1'b1;
            transmit_start   <= 1'b0;
            receive_start    <= 1'b0;
            data_to_transmit <= '0;
            rx_overflow      <= 1'b0;
        end else begin
            cs_n             <= !(state_nx inside {SETUP, LAUNCH, ARM, SHIFT, CAPTURE});
            transmit_start   <= state_nx == LAUNCH;
            receive_start    <= state_nx == LAUNCH;
            if (tx_pop) data_to_transmit <= tx_mem[tx_rp];
            rx_overflow      <= ovf_set || (rx_overflow && !clr_ovf);
        end
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed self-checking bench for spi_xfer_ctrl
module tb_spi_xfer_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0, rd_en = 1'b0, clr_ovf = 1'b0, hold = 1'b0;
    logic [31:0] wr_data = '0, mask = '0;
    logic tx_full, rx_empty, rx_overflow, busy, cs_n, transmit_start, receive_start;
    logic transmit_ready, receive_ready;
    logic [31:0] rd_data, data_to_transmit, data_in;
    int tcnt = 0, rcnt = 0;
    int n_starts = 0, n_bad_start = 0, n_unstable = 0, run = 0;
    int gaps[$];
    logic seen_low = 1'b0, prev_cs = 1'b1;
    logic [31:0] prev_dtt = '0;
    int errors = 0, checks = 0;
    int base_s, base_g, k;

    spi_xfer_ctrl dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
        .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty), .rx_overflow(rx_overflow),
        .clr_ovf(clr_ovf), .busy(busy), .cs_n(cs_n), .transmit_start(transmit_start),
        .data_to_transmit(data_to_transmit), .transmit_ready(transmit_ready),
        .receive_start(receive_start), .receive_ready(receive_ready), .data_in(data_in)
    );

    always #5 clk = ~clk;

    assign transmit_ready = !hold && tcnt == 0;
    assign receive_ready  = !hold && rcnt == 0;
    assign data_in        = data_to_transmit ^ mask;

    always @(posedge clk) begin
        if (transmit_start) tcnt <= 3;
        else if (tcnt > 0) tcnt <= tcnt - 1;
        if (receive_start) rcnt <= 4;
        else if (rcnt > 0) rcnt <= rcnt - 1;
    end

    always @(negedge clk) begin
        if (transmit_start) n_starts++;
        if (transmit_start != receive_start) n_bad_start++;
        if (!cs_n && !prev_cs && data_to_transmit != prev_dtt) n_unstable++;
        if (cs_n) run++;
        else begin
            if (prev_cs && seen_low) gaps.push_back(run);
            run = 0;
            seen_low = 1'b1;
        end
        prev_cs = cs_n;
        prev_dtt = data_to_transmit;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        wr_en = 1'b1;
        wr_data = w;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        chk({tag, "_nonempty"}, rx_empty, 0);
        chk(tag, rd_data, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wait_idle();
        int i = 0;
        while (busy && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(3);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_tx_start", transmit_start, 0);
        chk("rst_rx_start", receive_start, 0);
        chk("rst_dtt", data_to_transmit, 0);
        chk("rst_ovf", rx_overflow, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick(1);

        mask = 32'hB7915977;
        push(32'hA5A50F0F);
        chk("lat_cs_still_hi", cs_n, 1);
        tick(1);
        chk("lat_cs_lo", cs_n, 0);
        chk("lat_no_start_yet", transmit_start, 0);
        chk("single_dtt", data_to_transmit, 32'hA5A50F0F);
        tick(1);
        chk("lat_tx_start", transmit_start, 1);
        chk("lat_rx_start", receive_start, 1);
        tick(1);
        chk("start_one_cycle", transmit_start, 0);
        wait_idle();
        chk("single_starts", n_starts, 1);
        chk("single_dtt_held", data_to_transmit, 32'hA5A50F0F);
        pop_chk("single_rd", 32'h12345678);
        chk("single_rx_drained", rx_empty, 1);

        mask = '0;
        base_s = n_starts;
        base_g = gaps.size();
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1;
            wr_data = 32'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_idle();
        chk("b2b_starts", n_starts - base_s, 4);
        chk("b2b_ngaps", gaps.size() - base_g, 4);
        for (int i = 1; i < 4; i++) chk("b2b_gap", gaps[base_g + i], 2);
        for (int i = 1; i <= 4; i++) pop_chk("b2b_rd", 32'(i));
        chk("b2b_rx_empty", rx_empty, 1);

        hold = 1'b1;
        base_s = n_starts;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = 32'h10 + 32'(i);
            @(negedge clk);
            chk("tx_full", tx_full, i >= 3);
        end
        wr_en = 1'b0;
        tick(3);
        chk("hold_no_start", n_starts - base_s, 0);
        hold = 1'b0;
        wait_idle();
        chk("full_starts", n_starts - base_s, 4);
        for (int i = 0; i < 4; i++) pop_chk("full_rd", 32'h10 + 32'(i));
        chk("full_rx_empty", rx_empty, 1);

        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = 32'h20 + 32'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_idle();
        chk("ovf_set", rx_overflow, 1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("ovf_clr", rx_overflow, 0);
        clr_ovf = 1'b1;
        push(32'h25);
        k = 0;
        while (cs_n && k < 50) begin tick(1); k++; end
        while (!cs_n && k < 50) begin tick(1); k++; end
        clr_ovf = 1'b0;
        chk("ovf_frame_timeout", k < 50, 1);
        chk("ovf_set_wins", rx_overflow, 1);
        wait_idle();
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("ovf_clr2", rx_overflow, 0);
        for (int i = 0; i < 4; i++) pop_chk("ovf_rd", 32'h20 + 32'(i));
        chk("ovf_rx_empty", rx_empty, 1);

        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_data = 32'h30 + 32'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_idle();
        push(32'h34);
        tick(8);
        chk("capt_align", cs_n, 0);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk("capt_done", cs_n, 1);
        chk("simul_no_ovf", rx_overflow, 0);
        for (int i = 1; i <= 4; i++) pop_chk("simul_rd", 32'h30 + 32'(i));
        chk("simul_rx_empty", rx_empty, 1);

        base_s = n_starts;
        push(32'h40);
        tick(5);
        chk("mid_cs_lo", cs_n, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_cs_n", cs_n, 1);
        chk("async_busy", busy, 0);
        chk("async_rx_empty", rx_empty, 1);
        chk("async_dtt", data_to_transmit, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(10);
        chk("rst_no_push", rx_empty, 1);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk("rd_empty_ignored", rx_empty, 1);
        push(32'h50);
        wait_idle();
        pop_chk("post_rst_rd", 32'h50);
        chk("post_rst_empty", rx_empty, 1);
        chk("post_rst_starts", n_starts - base_s, 2);

        chk("start_pair", n_bad_start, 0);
        chk("dtt_stable", n_unstable, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
- CPU-side transaction sequencer directly upstream of the SPI mosi/miso shifters.
- Buffers CPU words in a TX FIFO and frames each word with an active-low chip select.
- Blips transmit_start/receive_start together, waits for both shifters to finish, and pushes the received word into an RX FIFO for the CPU to read.

Parameters:
- W_Data, `W_CPU (32): data word width.
- Depth, 4: entries in each of the TX and RX FIFOs; must be a power of 2, at least 2.
- W_Ptr, 2: log2(Depth).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  CPU push of wr_data into the TX FIFO.
- wr_data  input  W_Data  word to transmit.
- tx_full  output  1  TX FIFO holds Depth entries.
- rd_en  input  1  CPU pop of the RX FIFO head.
- rd_data  output  W_Data  RX FIFO head, show-ahead; valid while rx_empty=0.
- rx_empty  output  1  RX FIFO empty.
- rx_overflow  output  1  sticky; a received word was dropped.
- clr_ovf  input  1  clears rx_overflow.
- busy  output  1  FSM not in IDLE, or TX FIFO non-empty.
- cs_n  output  1  SPI chip select, active low.
- transmit_start  output  1  one-cycle start pulse to mosi.
- data_to_transmit  output  W_Data  word held for mosi.
- transmit_ready  input  1  from mosi.
- receive_start  output  1  one-cycle start pulse to miso.
- receive_ready  input  1  from miso.
- data_in  input  W_Data  received word from miso.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE; both FIFOs empty with pointers at 0.
  - cs_n=1, transmit_start=0, receive_start=0, data_to_transmit=0, rx_overflow=0.
  - tx_full=0, rx_empty=1, busy=0.
  - Reset mid-frame abandons the frame: no RX push, and the popped TX word is lost.
- All outputs are registered except rd_data, tx_full, rx_empty and busy, which decode from FIFO and FSM state.
- FSM states:
  - IDLE: cs_n=1. If the TX FIFO is non-empty and transmit_ready=1 and receive_ready=1, pop the TX head into data_to_transmit and go to SETUP.
  - SETUP: cs_n=0 for one cycle of select setup, then go to LAUNCH.
  - LAUNCH: transmit_start=1 and receive_start=1 for exactly this one cycle, then go to ARM.
  - ARM: wait for transmit_ready=0 (shifter accepted the start), then go to SHIFT. No timeout.
  - SHIFT: wait until transmit_ready=1 and receive_ready=1 in the same cycle, then go to CAPTURE.
  - CAPTURE: sample data_in. Push it if the RX FIFO is not full; otherwise drop it and set rx_overflow=1. Go to GAP.
  - GAP: cs_n=1 for one cycle of minimum deselect, then go to IDLE.
- cs_n=0 from SETUP through CAPTURE inclusive.
- data_to_transmit is stable from SETUP through GAP.
- Latency: wr_en sampled at edge N into an idle, empty controller gives cs_n low after edge N+1 and the start pulses high after edge N+2.
- Back-to-back frames are separated by GAP plus one IDLE cycle, so cs_n is high for 2 cycles minimum.
- TX FIFO boundaries:
  - wr_en while full with no pop in the same cycle: word ignored, no state change.
  - wr_en in the same cycle as an IDLE pop while full: accepted.
- RX FIFO boundaries:
  - rd_en while empty: ignored.
  - rd_en in the same cycle as a CAPTURE push while full: both occur, no overflow.
- Overflow flag:
  - clr_ovf clears rx_overflow.
  - If clr_ovf and a new overflow occur in the same cycle, the set wins.
- Pointers wrap modulo Depth. Occupancy counters are W_Ptr+1 bits wide.

Test Plan:
- Single frame: push 0xA5A50F0F; miso model returns 0x12345678 → one start pulse on each shifter, data_to_transmit=0xA5A50F0F held for the whole frame; then rx_empty=0, rd_data=0x12345678, busy=0.
- Back-to-back: push 4 words 0x1,0x2,0x3,0x4 in consecutive cycles → 4 frames in order; cs_n high for exactly 2 cycles between frames; RX FIFO holds 4 entries in order.
- TX full: with the shifters held not-ready, push 5 words → tx_full=1 after the 4th push; the 5th word is never transmitted.
- RX overflow: run 5 frames with no rd_en → 5th word dropped, rx_overflow=1; clr_ovf → 0. Same-cycle clr_ovf and overflow → stays 1.
- Reset mid-frame: assert rst during SHIFT → cs_n=1 immediately (asynchronously), FIFOs empty, no RX push; after release, a new push transmits normally.
- Simultaneous rd_en and CAPTURE with RX full → rx_overflow stays 0; the occupancy stays at Depth.
